// File: rtl/mont_arbiter_if.sv
// mont_arbiter_if
//   Bundles the request/grant side and the Montgomery-core side of the
//   shared-multiplier arbiter.
//   Parameter: WIDTH - operand/result width in bits.
//   Signals:
//     req[1:0]                      per-channel request
//     a0, b0, a1, b1                per-channel operand pairs
//     gnt[1:0], done[1:0]           one-hot capture / result pulses
//     result, busy, owner, op_count, error   arbiter status and product
//     core_start, core_a, core_b    command to the Montgomery core
//     core_done, core_result        response from the Montgomery core
//   Modports: master = requesters + core (environment), slave = arbiter.
interface mont_arbiter_if #(
  parameter int WIDTH = 1024
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             owner;
  logic [31:0]      op_count;
  logic             core_start;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_done;
  logic [WIDTH-1:0] core_result;
  logic             error;

  modport master (
    output req, a0, b0, a1, b1, core_done, core_result,
    input  gnt, done, result, busy, owner, op_count,
           core_start, core_a, core_b, error
  );

  modport slave (
    input  req, a0, b0, a1, b1, core_done, core_result,
    output gnt, done, result, busy, owner, op_count,
           core_start, core_a, core_b, error
  );
endinterface

// File: rtl/mont_arbiter.sv
// mont_arbiter
//   Shares one Montgomery multiplier core between channel 0 (squaring path)
//   and channel 1 (multiply path). A request's operands are captured, the
//   core is started, and the core's product is returned to the owning
//   channel. Ties are broken round-robin against the last served channel.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high reset
//     bus    - mont_arbiter_if.slave (requests, grants, results, core I/F)
//   Parameters: WIDTH (operand width), TIMEOUT_CYCLES (watchdog limit).
//   Optional feature macro: MONT_ARB_TIMEOUT_EN - adds a WAIT watchdog that
//   completes the operation with a zero result and flags error when the
//   core never answers.
module mont_arbiter #(
  parameter int WIDTH          = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  mont_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t           r_state;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_coreStart;
  logic             r_owner;
  logic             r_last;
  logic             r_error;
  logic [31:0]      r_opCount;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_coreA;
  logic [WIDTH-1:0] r_coreB;

  logic             w_winner;
  logic [1:0]       w_ownerOneHot;

`ifdef MONT_ARB_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_waitCnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // On a tie the channel that was not served last wins; a lone requester
  // always wins.
  assign w_winner      = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_ownerOneHot = r_owner ? 2'b10 : 2'b01;

  // Arbitration FSM. All outputs are registered here so gnt/core_start
  // appear in the ISSUE cycle and done appears in the RETURN cycle.
  // A core_done outside WAIT is a protocol violation and only sets error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_coreStart <= 1'b0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_error     <= 1'b0;
      r_opCount   <= 32'd0;
      r_result    <= '0;
      r_coreA     <= '0;
      r_coreB     <= '0;
`ifdef MONT_ARB_TIMEOUT_EN
      r_waitCnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.core_done) r_error <= 1'b1;
          if (bus.req != 2'b00) begin
            r_owner     <= w_winner;
            r_coreA     <= w_winner ? bus.a1 : bus.a0;
            r_coreB     <= w_winner ? bus.b1 : bus.b0;
            r_gnt       <= w_winner ? 2'b10 : 2'b01;
            r_coreStart <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.core_done) r_error <= 1'b1;
          r_gnt       <= 2'b00;
          r_coreStart <= 1'b0;
          r_state     <= WAIT;
`ifdef MONT_ARB_TIMEOUT_EN
          r_waitCnt   <= '0;
`endif
        end
        WAIT: begin
          if (bus.core_done) begin
            r_result <= bus.core_result;
            r_done   <= w_ownerOneHot;
            r_state  <= RETURN;
          end
`ifdef MONT_ARB_TIMEOUT_EN
          // Watchdog: after TIMEOUT_CYCLES silent WAIT cycles, finish the
          // operation with a zero product so the requester is released.
          else if (r_waitCnt == TO_LAST) begin
            r_error  <= 1'b1;
            r_result <= '0;
            r_done   <= w_ownerOneHot;
            r_state  <= RETURN;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
`endif
        end
        RETURN: begin
          if (bus.core_done) r_error <= 1'b1;
          r_done    <= 2'b00;
          r_last    <= r_owner;
          r_opCount <= r_opCount + 32'd1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.busy       = (r_state != IDLE);
  assign bus.owner      = r_owner;
  assign bus.op_count   = r_opCount;
  assign bus.core_start = r_coreStart;
  assign bus.core_a     = r_coreA;
  assign bus.core_b     = r_coreB;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_mont_arbiter.sv
// tb_mont_arbiter
//   Self-checking bench for mont_arbiter. A transaction-level reference
//   (operation start/finish edge timestamps) predicts every output each
//   cycle; directed scenarios add literal expectations, then a randomized
//   two-channel traffic phase runs against the same reference.
//   Macro MONT_ARB_TIMEOUT_EN enables the watchdog scenario and model rule.
module tb_mont_arbiter;
  localparam int W  = 32;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mont_arbiter_if #(.WIDTH(W)) bus ();

  mont_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic compareEn  = 1'b0;
  logic injectDone = 1'b0;
  logic coreMute   = 1'b0;
  logic presetFlag = 1'b0;
  int   coreLat    = 4;

  int         corePending = 0;
  logic [W-1:0] coreProduct = '0;

  // Reference model state: an operation is described by the edge that
  // granted it and the edge at which its result was taken.
  int           edgeCnt    = 0;
  logic         mBusy      = 1'b0;
  logic         mOwner     = 1'b0;
  logic         mLast      = 1'b1;
  logic         mError     = 1'b0;
  int           mGrantEdge = 0;
  int           mDoneEdge  = -1;
  logic [31:0]  mOpCount   = 32'd0;
  logic [W-1:0] mCoreA     = '0;
  logic [W-1:0] mCoreB     = '0;
  logic [W-1:0] mResult    = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic reportExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [W-1:0] x0,
                               input logic [W-1:0] y0, input logic [W-1:0] x1,
                               input logic [W-1:0] y1);
    bus.req = r;
    bus.a0  = x0;
    bus.b0  = y0;
    bus.a1  = x1;
    bus.b1  = y1;
  endtask

  task automatic waitGnt(output logic [1:0] g, output int cyc);
    g   = 2'b00;
    cyc = 0;
    while (g == 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      g = bus.gnt;
    end
    if (g == 2'b00) reportExpired("gnt_wait");
  endtask

  task automatic waitDone(output logic [1:0] d, output int cyc);
    d   = 2'b00;
    cyc = 0;
    while (d == 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      d = bus.done;
    end
    if (d == 2'b00) reportExpired("done_wait");
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Montgomery core stand-in: answers core_start with a product after
  // coreLat cycles, or emits a stray done on request. Runs just after the
  // falling edge so it sees the stimulus flags set on that edge.
  always begin
    @(negedge clk);
    #1;
    bus.core_done = 1'b0;
    if (corePending > 0) begin
      corePending--;
      if (corePending == 0) begin
        bus.core_done   = 1'b1;
        bus.core_result = coreProduct;
      end
    end else if (injectDone) begin
      bus.core_done   = 1'b1;
      bus.core_result = W'($urandom);
    end
    if (bus.core_start && !coreMute) begin
      corePending = coreLat;
      coreProduct = bus.core_a * bus.core_b;
    end
  end

  // Reference model, advanced on every rising edge from the sampled inputs.
  always @(posedge clk) begin
    edgeCnt++;
    if (reset) begin
      mBusy = 1'b0; mOwner = 1'b0; mLast = 1'b1; mError = 1'b0;
      mOpCount = 32'd0; mCoreA = '0; mCoreB = '0; mResult = '0;
      mDoneEdge = -1;
    end else if (!mBusy) begin
      if (bus.core_done) mError = 1'b1;
      if (bus.req != 2'b00) begin
        mOwner     = (bus.req == 2'b11) ? !mLast : bus.req[1];
        mCoreA     = mOwner ? bus.a1 : bus.a0;
        mCoreB     = mOwner ? bus.b1 : bus.b0;
        mBusy      = 1'b1;
        mGrantEdge = edgeCnt;
        mDoneEdge  = -1;
      end
    end else if (edgeCnt == mGrantEdge + 1) begin
      if (bus.core_done) mError = 1'b1;
    end else if (mDoneEdge < 0) begin
      if (bus.core_done) begin
        mResult   = bus.core_result;
        mDoneEdge = edgeCnt;
      end
`ifdef MONT_ARB_TIMEOUT_EN
      else if (edgeCnt - mGrantEdge - 1 == TO) begin
        mResult   = '0;
        mError    = 1'b1;
        mDoneEdge = edgeCnt;
      end
`endif
    end else begin
      if (bus.core_done) mError = 1'b1;
      mLast    = mOwner;
      mOpCount = mOpCount + 32'd1;
      mBusy    = 1'b0;
    end
    if (presetFlag) mOpCount = 32'hFFFF_FFFF;
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin : compare
    logic [1:0] eGnt;
    logic [1:0] eDone;
    if (compareEn) begin
      eGnt  = (mBusy && edgeCnt == mGrantEdge) ? (2'b01 << mOwner) : 2'b00;
      eDone = (mBusy && mDoneEdge >= 0 && edgeCnt == mDoneEdge) ?
              (2'b01 << mOwner) : 2'b00;
      checkOutput("gnt", bus.gnt, eGnt);
      checkOutput("core_start", bus.core_start, eGnt != 2'b00);
      checkOutput("done", bus.done, eDone);
      checkOutput("busy", bus.busy, mBusy);
      checkOutput("owner", bus.owner, mOwner);
      checkOutput("op_count", bus.op_count, mOpCount);
      checkOutput("error", bus.error, mError);
      checkOutput("core_a", bus.core_a, mCoreA);
      checkOutput("core_b", bus.core_b, mCoreB);
      checkOutput("gnt_done_excl", bus.gnt & bus.done, 2'b00);
      if (eDone != 2'b00) checkOutput("result", bus.result, mResult);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : main
    logic [1:0]   g;
    logic [1:0]   d;
    logic [1:0]   on;
    int           cyc;
    logic [W-1:0] ra0, rb0, ra1, rb1;

    applyStimulus(2'b00, '0, '0, '0, '0);
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_gnt", bus.gnt, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_core_start", bus.core_start, 0);
    checkOutput("rst_owner", bus.owner, 0);
    checkOutput("rst_op_count", bus.op_count, 0);
    checkOutput("rst_error", bus.error, 0);
    checkOutput("rst_core_a", bus.core_a, 0);
    checkOutput("rst_result", bus.result, 0);
    reset     = 1'b0;
    compareEn = 1'b1;

    // Single request on channel 0, core answers after 10 cycles
    $display("[TB] single request");
    coreLat = 10;
    applyStimulus(2'b01, 3, 5, 0, 0);
    waitGnt(g, cyc);
    checkOutput("single_gnt", g, 2'b01);
    checkOutput("single_gnt_latency", cyc, 1);
    checkOutput("single_core_start", bus.core_start, 1);
    checkOutput("single_core_a", bus.core_a, 3);
    checkOutput("single_core_b", bus.core_b, 5);
    applyStimulus(2'b00, 0, 0, 0, 0);
    waitDone(d, cyc);
    checkOutput("single_done", d, 2'b01);
    checkOutput("single_done_latency", cyc, 11);
    checkOutput("single_result", bus.result, 32'hF);
    @(negedge clk);
    checkOutput("single_op_count", bus.op_count, 1);
    checkOutput("single_idle", bus.busy, 0);

    // Spurious core_done while idle
    $display("[TB] spurious core_done");
    injectDone = 1'b1;
    @(negedge clk);
    injectDone = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("spurious_error", bus.error, 1);
    checkOutput("spurious_busy", bus.busy, 0);

    // Tie after reset: strict alternation over 6 operations
    $display("[TB] tie alternation");
    doReset();
    applyStimulus(2'b11, 7, 9, 11, 13);
    for (int i = 0; i < 6; i++) begin
      coreLat = $urandom_range(1, 5);
      waitGnt(g, cyc);
      checkOutput("tie_gnt", g, (i % 2 == 0) ? 2'b01 : 2'b10);
      waitDone(d, cyc);
      checkOutput("tie_done", d, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 5) applyStimulus(2'b00, 0, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    checkOutput("tie_op_count", bus.op_count, 6);

    // Reset in WAIT cycle 3; the late core_done then lands in IDLE
    $display("[TB] reset mid-operation");
    doReset();
    coreLat = 20;
    applyStimulus(2'b10, 0, 0, 21, 22);
    waitGnt(g, cyc);
    applyStimulus(2'b00, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_gnt", bus.gnt, 0);
    checkOutput("midrst_done", bus.done, 0);
    checkOutput("midrst_op_count", bus.op_count, 0);
    checkOutput("midrst_error", bus.error, 0);
    reset = 1'b0;
    cyc = 0;
    while (bus.error !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("late_done_error", bus.error, 1);

    // op_count wrap
    $display("[TB] op_count wrap");
    doReset();
    compareEn = 1'b0;
    @(negedge clk);
    force dut.r_opCount = 32'hFFFF_FFFF;
    presetFlag = 1'b1;
    @(negedge clk);
    release dut.r_opCount;
    presetFlag = 1'b0;
    @(negedge clk);
    compareEn = 1'b1;
    checkOutput("preset_op_count", bus.op_count, 32'hFFFF_FFFF);
    coreLat = 2;
    applyStimulus(2'b01, 4, 4, 0, 0);
    waitGnt(g, cyc);
    applyStimulus(2'b00, 0, 0, 0, 0);
    waitDone(d, cyc);
    @(negedge clk);
    checkOutput("wrap_op_count", bus.op_count, 0);

`ifdef MONT_ARB_TIMEOUT_EN
    // Watchdog: core never responds
    $display("[TB] watchdog timeout");
    doReset();
    coreMute = 1'b1;
    applyStimulus(2'b01, 6, 6, 0, 0);
    waitGnt(g, cyc);
    applyStimulus(2'b00, 0, 0, 0, 0);
    waitDone(d, cyc);
    checkOutput("to_done", d, 2'b01);
    checkOutput("to_latency", cyc, TO + 1);
    checkOutput("to_result", bus.result, 0);
    checkOutput("to_error", bus.error, 1);
    @(negedge clk);
    checkOutput("to_idle", bus.busy, 0);
    coreMute = 1'b0;
`endif

    // Randomized two-channel traffic
    $display("[TB] random traffic");
    doReset();
    on = 2'b00;
    ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      coreLat = $urandom_range(1, 8);
      for (int ch = 0; ch < 2; ch++) begin
        if (!on[ch]) begin
          if ($urandom_range(0, 3) == 0) begin
            on[ch] = 1'b1;
            if (ch == 0) begin ra0 = $urandom; rb0 = $urandom; end
            else begin ra1 = $urandom; rb1 = $urandom; end
          end
        end else if (bus.gnt[ch]) begin
          if ($urandom_range(0, 1) == 0) on[ch] = 1'b0;
          else if (ch == 0) begin ra0 = $urandom; rb0 = $urandom; end
          else begin ra1 = $urandom; rb1 = $urandom; end
        end
      end
      reset = (c == 1500);
      applyStimulus(on, ra0, rb0, ra1, rb1);
    end
    applyStimulus(2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_arbiter.md
Name: mont_arbiter

Overview:
Shares one Montgomery multiplier core between two requesters: channel 0 (squaring path) and channel 1 (multiply path) of the modular-exponentiation controller. Each request carries an operand pair. The block registers the operands, starts the core, waits for the core's done, and returns the product to the owning channel. Round-robin arbitration keeps either channel from starving the other.

Parameters:
WIDTH, 1024, operand and result width in bits (matches modulus width)
TIMEOUT_CYCLES, 4096, watchdog limit in cycles; used only with MONT_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  2  per-channel request; held high with operands stable until gnt seen
a0  in  WIDTH  channel 0 operand A
b0  in  WIDTH  channel 0 operand B
a1  in  WIDTH  channel 1 operand A
b1  in  WIDTH  channel 1 operand B
gnt  out  2  one-hot, one-cycle pulse: operands of that channel captured
done  out  2  one-hot, one-cycle pulse: result valid for that channel
result  out  WIDTH  product; valid only while done is nonzero
busy  out  1  high whenever state is not IDLE
owner  out  1  channel currently served; holds last value when idle
op_count  out  32  completed operations; wraps 0xFFFFFFFF -> 0
core_start  out  1  one-cycle start pulse to the Montgomery core
core_a  out  WIDTH  registered operand A to core
core_b  out  WIDTH  registered operand B to core
core_done  in  1  one-cycle done pulse from core
core_result  in  WIDTH  core product, valid with core_done
error  out  1  sticky protocol/timeout error, cleared only by reset

Behaviour:
- Clock and reset
  - Only clock is clk.
  - reset is synchronous, active-high.
  - On reset: state IDLE; gnt=0, done=0, core_start=0, busy=0, owner=0, error=0, op_count=0; result, core_a and core_b are all zeros; round-robin pointer last=1, so channel 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RETURN.
- IDLE
  - If req is nonzero at the clock edge, select the winner:
    - single requester: that channel;
    - both requesting: channel != last.
  - At the same edge: latch the winner's a/b into core_a/core_b, set owner, pulse gnt[winner], go to ISSUE.
- ISSUE (exactly 1 cycle)
  - core_start=1 and gnt[owner]=1 during this cycle.
  - Go to WAIT.
  - The requester may drop req from the next edge onward.
- WAIT
  - Hold core_a/core_b stable.
  - On core_done: latch core_result into result, go to RETURN.
- RETURN (exactly 1 cycle)
  - done[owner]=1 and result valid.
  - At the edge leaving RETURN: last<=owner, op_count increments, go to IDLE.
- Latency: req sampled in IDLE at edge k; gnt and core_start high in cycle k+1; done high exactly 1 cycle after the cycle core_done is seen.
- Back-to-back: after RETURN there is a minimum of 1 IDLE cycle before the next ISSUE.
- A channel whose req is still high in IDLE after its own RETURN is treated as a new request.
- Boundary conditions
  - core_done while in IDLE, ISSUE or RETURN: ignored (no state change) and error<=1.
  - req changing while in ISSUE/WAIT/RETURN: no effect; operands are already latched.
  - Reset mid-operation: returns to IDLE immediately, no done is issued, and the core is not aborted. A late core_done after reset arrives in IDLE, so it sets error.
- core_start is never asserted outside ISSUE.
- gnt and done are never both nonzero in the same cycle.

Optional Feature:
Macro: MONT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_done: error<=1, done[owner] pulses with result forced to all-zero, and the FSM proceeds through RETURN to IDLE (pointer and op_count updated as normal).
- Not defined: no counter exists, and WAIT holds indefinitely until core_done.

Test Plan:
- Single request: req=01, a0=3, b0=5; core model returns 0xF after 10 cycles -> gnt=01 one cycle later, core_a=3, core_b=5, core_start one pulse, done=01 with result=0xF one cycle after core_done, op_count=1.
- Tie after reset: req=11 held -> first gnt=01, done=01; next gnt=10, done=10; next gnt=01 (strict alternation over 6 ops), op_count=6.
- Spurious core_done in IDLE -> error=1 and stays 1; state remains IDLE, no done pulse.
- Reset asserted in WAIT cycle 3 -> next cycle busy=0, gnt=0, done=0, op_count=0, error=0; a later core_done sets error=1.
- op_count preset by forcing to 0xFFFFFFFF, then one operation -> op_count=0.
- With MONT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never responds -> done[owner] after 16 WAIT cycles, result=0, error=1, FSM back in IDLE.
